// File: rtl/dea_tx_framer_if.sv
// Byte-stream bus around the DEA transmit framer: encrypted-byte input, flush request,
// framed valid/ready output and overflow status. The master side is the framer itself.
interface dea_tx_framer_if;
    logic       in_valid;
    logic [7:0] din;
    logic       in_ready;
    logic       flush;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       overflow;

    modport master (
        input  in_valid, din, flush, tx_ready,
        output in_ready, tx_valid, tx_data, tx_last, overflow
    );

    modport slave (
        output in_valid, din, flush, tx_ready,
        input  in_ready, tx_valid, tx_data, tx_last, overflow
    );
endinterface

// File: rtl/dea_tx_framer.sv
// Buffers encrypted bytes in a FIFO and emits frames of SOF, length, payload and an
// XOR checksum (length XOR payload) over a valid/ready link.
module dea_tx_framer #(
    parameter int         DEPTH     = 16,
    parameter int         FRAME_LEN = 4,
    parameter logic [7:0] SOF       = 8'h7E
) (
    input  logic            dclk,
    input  logic            reset_n,
    dea_tx_framer_if.master bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   FLEN_C  = (AW + 1)'(FRAME_LEN);
    localparam logic [7:0]    FLEN_B  = 8'(FRAME_LEN);

    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_LEN, ST_PAY, ST_CHK} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          flush_q, flush_pend, overflow_q;
    logic [7:0]    len_q, chk_q, rem_q;
    logic [7:0]    head, launch_len;
    logic          in_ready_i, push, pop, hs, launch;
    logic          tx_valid_i, tx_last_i;
    logic [7:0]    tx_data_i;

    assign in_ready_i = (count < DEPTH_C);
    assign push       = bus.in_valid && in_ready_i;
    assign hs         = tx_valid_i && bus.tx_ready;
    assign pop        = (state == ST_PAY) && hs;
    assign head       = mem[rd_ptr];
    assign launch     = (state == ST_IDLE) &&
                        ((count >= FLEN_C) || (flush_pend && (count != '0)));
    assign launch_len = (count >= FLEN_C) ? FLEN_B : 8'(count);

    assign bus.in_ready = in_ready_i;
    assign bus.tx_valid = tx_valid_i;
    assign bus.tx_data  = tx_data_i;
    assign bus.tx_last  = tx_last_i;
    assign bus.overflow = overflow_q;

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outside IDLE the output is always valid, so a handshake is just tx_ready.
    always_comb begin
        state_nxt  = state;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h00;
        tx_last_i  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_valid_i = 1'b0;
                if (launch) state_nxt = ST_SOF;
            end
            ST_SOF: begin
                tx_data_i = SOF;
                if (bus.tx_ready) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                tx_data_i = len_q;
                if (bus.tx_ready) state_nxt = ST_PAY;
            end
            ST_PAY: begin
                tx_data_i = head;
                if (bus.tx_ready && (rem_q == 8'd1)) state_nxt = ST_CHK;
            end
            ST_CHK: begin
                tx_data_i = chk_q;
                tx_last_i = 1'b1;
                if (bus.tx_ready) state_nxt = ST_IDLE;
            end
            default: begin
                tx_valid_i = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    // A flush is registered once before it becomes pending, so it launches two edges later.
    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flush_q    <= 1'b0;
            flush_pend <= 1'b0;
            rem_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            flush_q <= bus.flush;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (flush_q) begin
                flush_pend <= 1'b1;
            end else if (launch || ((state == ST_IDLE) && (count == '0))) begin
                flush_pend <= 1'b0;
            end
            if ((state == ST_LEN) && hs) begin
                rem_q <= len_q;
            end else if (pop) begin
                rem_q <= rem_q - 1'b1;
            end
            if (bus.in_valid && !in_ready_i) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge dclk) begin
        if (push) mem[wr_ptr] <= bus.din;
        if (launch) begin
            len_q <= launch_len;
            chk_q <= launch_len;
        end else if (pop) begin
            chk_q <= chk_q ^ head;
        end
    end
endmodule

// File: tb/tb_dea_tx_framer.sv
// Randomised and directed bench for dea_tx_framer, with a frame-level reference model
// that builds the expected byte stream from payload lists.
module tb_dea_tx_framer;
    localparam logic [7:0] SOF_B = 8'h7E;

    logic dclk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [8:0] got [$];
    logic [8:0] exp [$];

    dea_tx_framer_if bus ();

    dea_tx_framer #(.DEPTH(16), .FRAME_LEN(4), .SOF(8'h7E)) dut (
        .dclk    (dclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 dclk = ~dclk;

    // Record every accepted output byte with its last flag.
    always @(negedge dclk) begin
        if (reset_n && bus.tx_valid && bus.tx_ready) got.push_back({bus.tx_last, bus.tx_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add_frame(input logic [7:0] pl[$]);
        logic [7:0] c;
        c = 8'(pl.size());
        exp.push_back({1'b0, SOF_B});
        exp.push_back({1'b0, c});
        foreach (pl[i]) begin
            exp.push_back({1'b0, pl[i]});
            c = c ^ pl[i];
        end
        exp.push_back({1'b1, c});
    endfunction

    task automatic cyc();
        @(posedge dclk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.din      = 8'h00;
        bus.flush    = 1'b0;
        bus.tx_ready = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.din      = b;
        n            = 0;
        do begin
            @(negedge dclk);
            acc = bus.in_ready;
            cyc();
            n++;
        end while (!acc && n < 100);
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout byte %h never accepted, expected in_ready=1", b);
        end
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
    endtask

    task automatic wait_got(input int n, input int limit);
        int c = 0;
        while (got.size() < n && c < limit) begin
            cyc();
            c++;
        end
    endtask

    task automatic wait_sof(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge dclk);
            if (bus.tx_valid) break;
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.din      = 8'h00;
        bus.flush    = 1'b0;
        bus.tx_ready = 1'b0;
        @(posedge dclk);
        @(negedge dclk);
        n_cmp += 5;
        if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got %b expected 0", bus.tx_valid); end
        if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data got %h expected 00", bus.tx_data); end
        if (bus.tx_last !== 1'b0) begin n_bad++; $display("FAIL rst_tx_last got %b expected 0", bus.tx_last); end
        if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %b expected 0", bus.overflow); end
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b expected 1", bus.in_ready); end
        cyc();
    endtask

    task automatic test_basic();
        logic [7:0] pl[$];
        logic [8:0] g;
        int base;
        do_reset();
        base = got.size();
        exp.delete();
        pl = {8'h12, 8'h34, 8'h56, 8'h78};
        add_frame(pl);
        bus.tx_ready = 1'b1;
        foreach (pl[i]) push_byte(pl[i]);
        @(negedge dclk);
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat_idle tx_valid got %b expected 0", bus.tx_valid); end
        @(negedge dclk);
        n_cmp++;
        if ({bus.tx_valid, bus.tx_data} !== {1'b1, SOF_B}) begin
            n_bad++; $display("FAIL basic_lat_sof got %b/%h expected 1/7e", bus.tx_valid, bus.tx_data);
        end
        cyc();
        wait_got(base + exp.size(), 40);
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL basic_count got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (base + i < got.size()) ? got[base + i] : 'x;
            n_cmp++;
            if (g !== exp[i]) begin n_bad++; $display("FAIL basic[%0d] got %h expected %h", i, g, exp[i]); end
        end
        repeat (3) cyc();
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_after tx_valid got %b expected 0", bus.tx_valid); end
    endtask

    task automatic test_flush_short();
        logic [7:0] pl[$];
        logic [8:0] g;
        int base;
        do_reset();
        base = got.size();
        exp.delete();
        pl = {8'h11, 8'h22};
        add_frame(pl);
        bus.tx_ready = 1'b1;
        foreach (pl[i]) push_byte(pl[i]);
        repeat (5) cyc();
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL short_noflush tx_valid got %b expected 0", bus.tx_valid); end
        pulse_flush();
        @(negedge dclk);
        @(negedge dclk);
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL flush_lat_pre tx_valid got %b expected 0", bus.tx_valid); end
        @(negedge dclk);
        n_cmp++;
        if (bus.tx_valid !== 1'b1) begin n_bad++; $display("FAIL flush_lat_sof tx_valid got %b expected 1", bus.tx_valid); end
        cyc();
        wait_got(base + exp.size(), 40);
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL short_count got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (base + i < got.size()) ? got[base + i] : 'x;
            n_cmp++;
            if (g !== exp[i]) begin n_bad++; $display("FAIL short[%0d] got %h expected %h", i, g, exp[i]); end
        end
        repeat (10) cyc();
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL short_nomore got %0d expected %0d", got.size() - base, exp.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pl[$];
        logic [8:0] g;
        int base;
        do_reset();
        base = got.size();
        exp.delete();
        pl = {8'h12, 8'h34, 8'h56, 8'h78};
        add_frame(pl);
        foreach (pl[i]) push_byte(pl[i]);
        wait_sof(20);
        @(posedge dclk);
        #1 bus.tx_ready = 1'b1;
        cyc();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge dclk);
            n_cmp++;
            if ({bus.tx_valid, bus.tx_last, bus.tx_data} !== {2'b10, 8'h04}) begin
                n_bad++; $display("FAIL bp_hold[%0d] got v%b l%b %h expected v1 l0 04", i, bus.tx_valid, bus.tx_last, bus.tx_data);
            end
        end
        @(posedge dclk);
        #1 bus.tx_ready = 1'b1;
        wait_got(base + exp.size(), 40);
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL bp_count got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (base + i < got.size()) ? got[base + i] : 'x;
            n_cmp++;
            if (g !== exp[i]) begin n_bad++; $display("FAIL bp[%0d] got %h expected %h", i, g, exp[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] pl[$];
        logic [8:0] g;
        int base;
        do_reset();
        base = got.size();
        exp.delete();
        for (int f = 0; f < 4; f++) begin
            pl.delete();
            for (int j = 0; j < 4; j++) pl.push_back(8'(f * 4 + j));
            add_frame(pl);
        end
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        @(negedge dclk);
        n_cmp += 2;
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b expected 0", bus.in_ready); end
        if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_before got %b expected 0", bus.overflow); end
        @(posedge dclk);
        #1;
        bus.in_valid = 1'b1;
        bus.din      = 8'hFF;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge dclk);
        n_cmp++;
        if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b expected 1", bus.overflow); end
        @(posedge dclk);
        #1 bus.tx_ready = 1'b1;
        wait_got(base + exp.size(), 120);
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL ovf_count got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (base + i < got.size()) ? got[base + i] : 'x;
            n_cmp++;
            if (g !== exp[i]) begin n_bad++; $display("FAIL ovf[%0d] got %h expected %h", i, g, exp[i]); end
        end
        repeat (5) cyc();
        n_cmp += 2;
        if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b expected 1", bus.overflow); end
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL ovf_extra got %0d expected %0d", got.size() - base, exp.size()); end
    endtask

    task automatic test_empty_flush();
        logic [7:0] pl[$];
        logic [8:0] g;
        int base;
        do_reset();
        base = got.size();
        exp.delete();
        pl = {8'hAB};
        add_frame(pl);
        bus.tx_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < 10; i++) begin
            @(negedge dclk);
            n_cmp++;
            if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL empty_flush[%0d] tx_valid got %b expected 0", i, bus.tx_valid); end
        end
        cyc();
        push_byte(8'hAB);
        repeat (10) cyc();
        n_cmp++;
        if (got.size() !== base) begin n_bad++; $display("FAIL single_noframe got %0d bytes expected 0", got.size() - base); end
        pulse_flush();
        wait_got(base + exp.size(), 40);
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL single_count got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (base + i < got.size()) ? got[base + i] : 'x;
            n_cmp++;
            if (g !== exp[i]) begin n_bad++; $display("FAIL single[%0d] got %h expected %h", i, g, exp[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pl[$];
        logic [8:0] g;
        int base;
        do_reset();
        pl = {8'h12, 8'h34, 8'h56, 8'h78};
        foreach (pl[i]) push_byte(pl[i]);
        wait_sof(20);
        @(posedge dclk);
        #1 bus.tx_ready = 1'b1;
        repeat (3) cyc();
        bus.tx_ready = 1'b0;
        @(negedge dclk);
        n_cmp++;
        if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h34}) begin
            n_bad++; $display("FAIL mid_pay got %b/%h expected 1/34", bus.tx_valid, bus.tx_data);
        end
        @(posedge dclk);
        #1 reset_n = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b expected 0", bus.tx_valid); end
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready got %b expected 1", bus.in_ready); end
        cyc();
        reset_n = 1'b1;
        cyc();
        base = got.size();
        exp.delete();
        add_frame(pl);
        bus.tx_ready = 1'b1;
        foreach (pl[i]) push_byte(pl[i]);
        wait_got(base + exp.size(), 40);
        repeat (4) cyc();
        n_cmp++;
        if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL rerun_count got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (base + i < got.size()) ? got[base + i] : 'x;
            n_cmp++;
            if (g !== exp[i]) begin n_bad++; $display("FAIL rerun[%0d] got %h expected %h", i, g, exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] pl[$];
        logic [7:0] fr[$];
        logic [8:0] g;
        logic acc;
        int base, k, r, n, idx, cycles;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            base = got.size();
            exp.delete();
            pl.delete();
            k = $urandom_range(3, 6);
            r = $urandom_range(1, 3);
            n = 4 * k + r;
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            for (int f = 0; f <= k; f++) begin
                fr.delete();
                for (int j = f * 4; j < n && j < f * 4 + 4; j++) fr.push_back(pl[j]);
                add_frame(fr);
            end
            idx = 0;
            cycles = 0;
            while (idx < n && cycles < 2000) begin
                bus.tx_ready = ($urandom_range(0, 3) != 0);
                if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.din      = pl[idx];
                end
                @(negedge dclk);
                acc = bus.in_valid && bus.in_ready;
                cyc();
                cycles++;
                if (acc) begin
                    idx++;
                    bus.in_valid = 1'b0;
                end
            end
            bus.in_valid = 1'b0;
            bus.tx_ready = 1'b1;
            wait_got(base + 7 * k, 300);
            pulse_flush();
            wait_got(base + exp.size(), 60);
            repeat (3) cyc();
            n_cmp += 2;
            if (got.size() !== base + exp.size()) begin n_bad++; $display("FAIL rand%0d_count got %0d expected %0d", rep, got.size() - base, exp.size()); end
            if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rand%0d_overflow got %b expected 0", rep, bus.overflow); end
            for (int i = 0; i < exp.size(); i++) begin
                g = (base + i < got.size()) ? got[base + i] : 'x;
                n_cmp++;
                if (g !== exp[i]) begin n_bad++; $display("FAIL rand%0d[%0d] got %h expected %h", rep, i, g, exp[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_short();
        test_backpressure();
        test_overflow();
        test_empty_flush();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
